// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues imem requests, buffers one instruction for decode.
// Applies redirects with flush, enforces the imem address window, and parks in HALT/ERROR until reset.
module fetch_sequencer #(
  parameter logic [31:0] IMEM_START  = 32'h0000_0000,
  parameter logic [31:0] IMEM_END    = 32'h0000_0064,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_accept,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halt,
  output logic        error,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DELIVER, S_HALT, S_ERROR} state_t;

  localparam int             TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [31:0]    WIN_SPAN = IMEM_END - IMEM_START;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic [31:0]   count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [32:0]   next_pc;

  // Offset compare also rejects addresses below IMEM_START through unsigned wrap.
  function automatic logic legal_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - IMEM_START;
    return (off <= WIN_SPAN) && (a[1:0] == 2'b00);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= IMEM_START;
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    next_pc    = {1'b0, pc_q} + 33'd4;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = IMEM_START;
        end
      end
      S_FETCH: begin
        if (redirect_valid) begin
          tmo_d = '0;
          if (legal_addr(redirect_target)) pc_d = redirect_target;
          else                             state_d = S_HALT;
        end else if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          tmo_d      = '0;
          state_d    = S_DELIVER;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DELIVER: begin
        // Redirect flushes the buffer even if decode accepts in the same cycle.
        if (redirect_valid) begin
          if (legal_addr(redirect_target)) begin
            pc_d    = redirect_target;
            state_d = S_FETCH;
          end else begin
            state_d = S_HALT;
          end
        end else if (instr_accept) begin
          count_d = count_q + 32'd1;
          if (next_pc <= {1'b0, IMEM_END}) begin
            pc_d    = next_pc[31:0];
            state_d = S_FETCH;
          end else begin
            state_d = S_HALT;
          end
        end
      end
      default: ;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_DELIVER);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halt        = (state_q == S_HALT);
  assign error       = (state_q == S_ERROR);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: imem responder model plus expected (pc, instr) queue.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, imem_ready, instr_accept, redirect_valid;
  logic [31:0] imem_rdata, redirect_target;
  logic        imem_req, instr_valid, halt, error;
  logic [31:0] imem_addr, instr, instr_pc, fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  int   req_cnt = 0;
  int   req8    = 0;
  int   wcnt    = 0;
  logic mem_en  = 1'b1;
  logic slow8   = 1'b0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_accept(instr_accept),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .error(error), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h0000_0013 | (a << 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // imem model: answers after a per-address delay, only while a request is pending.
  always @(negedge clk) begin
    if (mem_en && imem_req) begin
      if (wcnt >= ((slow8 && imem_addr == 32'h8) ? 3 : 0)) begin
        imem_ready = 1'b1;
        imem_rdata = word_of(imem_addr);
        wcnt = 0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      wcnt = 0;
    end
  end

  // Observe the current cycle (inputs already driven), then advance to the next negedge.
  task automatic cycle();
    exp_t e;
    if (imem_req) req_cnt++;
    if (imem_req && imem_addr == 32'h8) req8++;
    if (!reset && instr_valid && instr_accept && !redirect_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_instr", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.ins);
      end
      exp_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; instr_accept = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; slow8 = 1'b0; mem_en = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    sb.delete();
    exp_cnt = 0;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc  = a;
    e.ins = word_of(a);
    sb.push_back(e);
  endtask

  task automatic kick();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 50) begin cycle(); n++; end
    if (!instr_valid) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_count(input string tag, input int c);
    int n = 0;
    while (fetch_count != c && n < 100) begin cycle(); n++; end
    if (fetch_count != c) chk(tag, fetch_count, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; instr_accept = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    do_reset();

    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_halt", halt, 0);
    chk("rst_error", error, 0);
    chk("rst_fetch_count", fetch_count, 0);

    // T1: full run to the end of the window.
    for (int a = 0; a <= 32'h64; a += 4) push_exp(a);
    instr_accept = 1'b1;
    kick();
    n = 0;
    while (!halt && n < 200) begin cycle(); n++; end
    chk("t1_halt", halt, 1);
    chk("t1_fetch_count", fetch_count, 26);
    chk("t1_model_count", fetch_count, exp_cnt);
    chk("t1_sb_empty", sb.size(), 0);
    req_cnt = 0;
    redirect_valid = 1'b1; redirect_target = 32'h10;
    cycle();
    redirect_valid = 1'b0;
    kick();
    for (int i = 0; i < 3; i++) cycle();
    chk("t1_no_req_after_halt", req_cnt, 0);
    chk("t1_halt_sticky", halt, 1);

    // T2: slow imem at 0x08.
    do_reset();
    slow8 = 1'b1; instr_accept = 1'b1; req8 = 0;
    for (int a = 0; a < 16; a += 4) push_exp(a);
    kick();
    wait_count("t2_timeout", 4);
    chk("t2_req_cycles_at_08", req8, 4);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_model_count", fetch_count, exp_cnt);

    // T3: decode stalls for 5 cycles.
    do_reset();
    push_exp(0);
    kick();
    wait_valid("t3_no_valid");
    req_cnt = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("t3_valid_held", instr_valid, 1);
    chk("t3_pc_held", instr_pc, 0);
    chk("t3_instr_held", instr, word_of(0));
    chk("t3_no_req", req_cnt, 0);
    chk("t3_count_held", fetch_count, 0);
    instr_accept = 1'b1;
    cycle();
    instr_accept = 1'b0;
    chk("t3_count_after_accept", fetch_count, 1);
    chk("t3_valid_after_accept", instr_valid, 0);

    // T4: redirect beats accept; illegal targets halt.
    do_reset();
    kick();
    wait_valid("t4_no_valid");
    redirect_valid = 1'b1; redirect_target = 32'h40; instr_accept = 1'b1;
    push_exp(32'h40);
    cycle();
    redirect_valid = 1'b0;
    chk("t4_valid_flushed", instr_valid, 0);
    chk("t4_count_unchanged", fetch_count, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr_target", imem_addr, 32'h40);
    wait_count("t4_no_accept_40", 1);
    n = 0;
    while (!(imem_req && imem_addr == 32'h44) && n < 20) begin cycle(); n++; end
    redirect_valid = 1'b1; redirect_target = 32'h42;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_halt_misaligned", halt, 1);
    chk("t4_halt_no_req", imem_req, 0);
    chk("t4_halt_count", fetch_count, 1);
    chk("t4_sb_empty", sb.size(), 0);
    do_reset();
    kick();
    wait_valid("t4b_no_valid");
    redirect_valid = 1'b1; redirect_target = 32'h68;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_halt_out_of_window", halt, 1);
    chk("t4b_valid", instr_valid, 0);

    // T5: imem never answers.
    do_reset();
    mem_en = 1'b0; req_cnt = 0;
    kick();
    n = 0;
    while (!error && n < 40) begin cycle(); n++; end
    chk("t5_fetch_cycles", req_cnt, 16);
    chk("t5_error", error, 1);
    chk("t5_no_req", imem_req, 0);
    chk("t5_no_halt", halt, 0);
    do_reset();
    chk("t5_error_cleared", error, 0);
    chk("t5_pc_reset", imem_addr, 0);

    // T6: reset while a response is arriving.
    do_reset();
    instr_accept = 1'b1;
    push_exp(0); push_exp(4);
    kick();
    n = 0;
    while (!(fetch_count == 2 && imem_req) && n < 30) begin cycle(); n++; end
    chk("t6_in_fetch_at_08", imem_addr, 32'h8);
    reset = 1'b1;
    cycle();
    chk("t6_valid", instr_valid, 0);
    chk("t6_count", fetch_count, 0);
    chk("t6_req", imem_req, 0);
    chk("t6_addr", imem_addr, 0);
    reset = 1'b0; instr_accept = 1'b0;
    cycle();
    chk("t6_stays_idle", imem_req, 0);
    chk("t6_still_no_valid", instr_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
